// File: rtl/i2s_rx_master.sv
// i2s_rx_master: I2S master receiver generating SCK/WS and deserialising 24-bit mic words into strobed samples.
module i2s_rx_master #(
  parameter int CLK_DIV      = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int CHANNEL_MODE = 0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        enable_i,
  input  logic        sd_i,
  output logic        sck_o,
  output logic        ws_o,
  output logic        sample_valid_o,
  output logic [23:0] sample_o,
  output logic        channel_o
);
  localparam int PW = $clog2(2 * CLK_DIV);
  localparam logic [PW-1:0] HALF = PW'(CLK_DIV);
  localparam logic [PW-1:0] LAST = PW'(2 * CLK_DIV - 1);
  localparam logic [PW-1:0] CAP  = PW'(CLK_DIV + SYNC_STAGES);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, STOPPING = 2'd2;
  localparam logic EMIT_L = CHANNEL_MODE != 1;
  localparam logic EMIT_R = CHANNEL_MODE != 0;

  logic [1:0]             state_q, state_d;
  logic [PW-1:0]          phase_q, phase_d;
  logic [5:0]             slot_q, slot_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES:0]   sync_w;
  logic [22:0]            shift_q, shift_d;
  logic [23:0]            word, sample_q;
  logic                   sck_q, ws_q, valid_q, chan_q;
  logic                   run, wrap, cap, strobe;

  always_comb begin
    run     = state_q != IDLE;
    wrap    = phase_q == LAST;
    sync_w  = {sync_q, sd_i};
    word    = {shift_q, sync_w[SYNC_STAGES]};
    // data slots are 1..24 of each half-frame (one-bit I2S delay after WS change)
    cap     = run && phase_q == CAP && slot_q[4:0] >= 5'd1 && slot_q[4:0] <= 5'd24;
    strobe  = cap && slot_q[4:0] == 5'd24 && (slot_q[5] ? EMIT_R : EMIT_L);
    phase_d = run && !wrap ? phase_q + 1'b1 : '0;
    slot_d  = !run ? 6'd0 : wrap ? slot_q + 6'd1 : slot_q;
    shift_d = cap ? word[22:0] : shift_q;
    state_d = state_q == IDLE ? (enable_i ? RUN : IDLE)
            : enable_i ? RUN
            : state_q == RUN ? STOPPING
            : wrap && slot_q == 6'd63 ? IDLE : STOPPING;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      slot_q   <= '0;
      sync_q   <= '0;
      shift_q  <= '0;
      sck_q    <= 1'b0;
      ws_q     <= 1'b0;
      valid_q  <= 1'b0;
      sample_q <= '0;
      chan_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      slot_q  <= slot_d;
      sync_q  <= sync_w[SYNC_STAGES-1:0];
      shift_q <= shift_d;
      sck_q   <= phase_d >= HALF;
      ws_q    <= slot_d[5];
      valid_q <= strobe;
      if (strobe) begin
        sample_q <= word;
        chan_q   <= slot_q[5];
      end
    end
  end

  assign sck_o          = sck_q;
  assign ws_o           = ws_q;
  assign sample_valid_o = valid_q;
  assign sample_o       = sample_q;
  assign channel_o      = chan_q;
endmodule

// File: tb/tb_i2s_rx_master.sv
// tb_i2s_rx_master: three instances (left-only, right-only, both) share one mic model driving sd on SCK falls.
module tb_i2s_rx_master;
  typedef struct {int k; int c; logic [23:0] d; logic ch;} st;
  logic        clk = 1'b0, rst_n = 1'b0, en = 1'b0, junk = 1'b0;
  logic [23:0] lw = '0, rw = '0;
  logic [5:0]  mslot = '0;
  logic        sd;
  logic        sck [3], ws [3], v [3], ch [3];
  logic [23:0] smp [3];
  int          cyc = 0, base = 0, checks = 0, errors = 0;
  st           sq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    i2s_rx_master #(.CLK_DIV(4), .SYNC_STAGES(2), .CHANNEL_MODE(g)) dut (
      .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .sd_i(sd),
      .sck_o(sck[g]), .ws_o(ws[g]), .sample_valid_o(v[g]),
      .sample_o(smp[g]), .channel_o(ch[g]));
  end

  // Mic: slot index advances on every SCK fall, data for that slot is driven right away
  always @(negedge sck[2] or negedge rst_n) mslot <= !rst_n ? 6'd0 : mslot + 6'd1;

  function automatic logic mic_bit(int s, logic [23:0] l, logic [23:0] r, logic j);
    if (s >= 1 && s <= 24) return l[24 - s];
    if (s >= 33 && s <= 56) return r[56 - s];
    return j;
  endfunction
  assign sd = mic_bit(int'(mslot), lw, rw, junk);

  always @(negedge clk)
    for (int k = 0; k < 3; k++) if (v[k]) sq.push_back('{k, cyc - base, smp[k], ch[k]});

  task automatic start();
    @(negedge clk);
    en = 1'b1;
    base = cyc + 1;
    sq.delete();
  endtask

  task automatic step_to(int n);
    while (cyc - base < n) @(negedge clk);
  endtask

  task automatic test_reset();
    int tog, nz;
    tog = 0; nz = 0;
    rst_n = 1'b0; en = 1'b0; junk = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({sck[k], ws[k], v[k], ch[k], smp[k]} !== 28'd0) begin errors++; $display("FAIL reset_state dut%0d got %h want 0", k, {sck[k], ws[k], v[k], ch[k], smp[k]}); end
    end
    rst_n = 1'b1;
    repeat (1000) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (sck[k] !== 1'b0) tog++;
        if ({ws[k], v[k], ch[k], smp[k]} !== 27'd0) nz++;
      end
    end
    checks++;
    if (tog !== 0) begin errors++; $display("FAIL idle_sck got %0d high cycles want 0", tog); end
    checks++;
    if (nz !== 0) begin errors++; $display("FAIL idle_outputs got %0d nonzero cycles want 0", nz); end
    junk = 1'b0;
  endtask

  task automatic test_left_only();
    st e [4];
    st g;
    e = '{'{0, 199, 24'h800001, 1'b0}, '{2, 199, 24'h800001, 1'b0},
          '{1, 455, 24'h7FFFFF, 1'b1}, '{2, 455, 24'h7FFFFF, 1'b1}};
    lw = 24'h800001; rw = 24'h7FFFFF;
    start();
    step_to(3);  checks++; if (sck[0] !== 1'b0) begin errors++; $display("FAIL sck_c3 got %b want 0", sck[0]); end
    step_to(4);  checks++; if (sck[0] !== 1'b1) begin errors++; $display("FAIL sck_c4 got %b want 1", sck[0]); end
    step_to(8);  checks++; if (sck[0] !== 1'b0) begin errors++; $display("FAIL sck_c8 got %b want 0", sck[0]); end
    step_to(12); checks++; if (sck[0] !== 1'b1) begin errors++; $display("FAIL sck_c12 got %b want 1", sck[0]); end
    step_to(80); en = 1'b0;
    step_to(255); checks++; if (ws[0] !== 1'b0) begin errors++; $display("FAIL ws_c255 got %b want 0", ws[0]); end
    step_to(256); checks++; if (ws[0] !== 1'b1) begin errors++; $display("FAIL ws_c256 got %b want 1", ws[0]); end
    step_to(300); checks++; if (smp[1] !== 24'h0) begin errors++; $display("FAIL right_only_untouched got %h want 000000", smp[1]); end
    step_to(511); checks++; if ({sck[0], ws[0]} !== 2'b11) begin errors++; $display("FAIL frame_last got %b want 11", {sck[0], ws[0]}); end
    step_to(512); checks++; if ({sck[0], ws[0]} !== 2'b00) begin errors++; $display("FAIL stop_idle got %b want 00", {sck[0], ws[0]}); end
    step_to(700);
    checks++;
    if ({sck[0], sck[1], sck[2]} !== 3'b000) begin errors++; $display("FAIL stop_sck got %b want 000", {sck[0], sck[1], sck[2]}); end
    checks++;
    if ({smp[0], ch[0]} !== {24'h800001, 1'b0}) begin errors++; $display("FAIL left_hold got %h/%b want 800001/0", smp[0], ch[0]); end
    checks++;
    if (sq.size() != 4) begin errors++; $display("FAIL left_count got %0d want 4", sq.size()); end
    for (int i = 0; i < 4; i++) begin
      g = '{-1, -1, 24'h0, 1'b0};
      if (i < sq.size()) g = sq[i];
      checks++;
      if (g.k != e[i].k || g.c != e[i].c || g.d !== e[i].d || g.ch !== e[i].ch) begin
        errors++; $display("FAIL left_strobe%0d got dut%0d c%0d %h ch%b want dut%0d c%0d %h ch%b", i, g.k, g.c, g.d, g.ch, e[i].k, e[i].c, e[i].d, e[i].ch);
      end
    end
  endtask

  task automatic test_both_channels();
    st e [8];
    st g;
    e = '{'{0, 199, 24'h123456, 1'b0}, '{2, 199, 24'h123456, 1'b0},
          '{1, 455, 24'h7FFFFF, 1'b1}, '{2, 455, 24'h7FFFFF, 1'b1},
          '{0, 711, 24'h123456, 1'b0}, '{2, 711, 24'h123456, 1'b0},
          '{1, 967, 24'h7FFFFF, 1'b1}, '{2, 967, 24'h7FFFFF, 1'b1}};
    lw = 24'h123456; rw = 24'h7FFFFF;
    start();
    step_to(600); en = 1'b0;
    step_to(1100);
    checks++;
    if (sck[2] !== 1'b0) begin errors++; $display("FAIL both_stop_sck got %b want 0", sck[2]); end
    checks++;
    if (sq.size() != 8) begin errors++; $display("FAIL both_count got %0d want 8", sq.size()); end
    for (int i = 0; i < 8; i++) begin
      g = '{-1, -1, 24'h0, 1'b0};
      if (i < sq.size()) g = sq[i];
      checks++;
      if (g.k != e[i].k || g.c != e[i].c || g.d !== e[i].d || g.ch !== e[i].ch) begin
        errors++; $display("FAIL both_strobe%0d got dut%0d c%0d %h ch%b want dut%0d c%0d %h ch%b", i, g.k, g.c, g.d, g.ch, e[i].k, e[i].c, e[i].d, e[i].ch);
      end
    end
  endtask

  task automatic test_ignored_slots();
    st e [4];
    st g;
    e = '{'{0, 199, 24'h000000, 1'b0}, '{2, 199, 24'h000000, 1'b0},
          '{1, 455, 24'hFFFFFE, 1'b1}, '{2, 455, 24'hFFFFFE, 1'b1}};
    junk = 1'b1; lw = 24'h000000; rw = 24'hFFFFFE;
    start();
    step_to(80); en = 1'b0;
    step_to(700);
    junk = 1'b0;
    checks++;
    if (sq.size() != 4) begin errors++; $display("FAIL ignored_count got %0d want 4", sq.size()); end
    for (int i = 0; i < 4; i++) begin
      g = '{-1, -1, 24'h0, 1'b0};
      if (i < sq.size()) g = sq[i];
      checks++;
      if (g.k != e[i].k || g.c != e[i].c || g.d !== e[i].d || g.ch !== e[i].ch) begin
        errors++; $display("FAIL ignored_strobe%0d got dut%0d c%0d %h ch%b want dut%0d c%0d %h ch%b", i, g.k, g.c, g.d, g.ch, e[i].k, e[i].c, e[i].d, e[i].ch);
      end
    end
  endtask

  task automatic test_stop_resume();
    st e [8];
    st g;
    int bs, bw;
    logic xs, xw;
    e = '{'{0, 199, 24'h00A5A5, 1'b0}, '{2, 199, 24'h00A5A5, 1'b0},
          '{1, 455, 24'h5A5A00, 1'b1}, '{2, 455, 24'h5A5A00, 1'b1},
          '{0, 711, 24'h00A5A5, 1'b0}, '{2, 711, 24'h00A5A5, 1'b0},
          '{1, 967, 24'h5A5A00, 1'b1}, '{2, 967, 24'h5A5A00, 1'b1}};
    bs = 0; bw = 0;
    lw = 24'h00A5A5; rw = 24'h5A5A00;
    start();
    for (int r = 0; r <= 1100; r++) begin
      step_to(r);
      xs = r < 1024 && (r % 8) >= 4;
      xw = r < 1024 && ((r / 256) % 2) == 1;
      if (sck[2] !== xs) bs++;
      if (ws[2] !== xw) bw++;
      if (r == 80) en = 1'b0;
      if (r == 320) en = 1'b1;
      if (r == 600) en = 1'b0;
    end
    checks++;
    if (bs !== 0) begin errors++; $display("FAIL resume_sck got %0d wrong cycles want 0", bs); end
    checks++;
    if (bw !== 0) begin errors++; $display("FAIL resume_ws got %0d wrong cycles want 0", bw); end
    checks++;
    if (sq.size() != 8) begin errors++; $display("FAIL resume_count got %0d want 8", sq.size()); end
    for (int i = 0; i < 8; i++) begin
      g = '{-1, -1, 24'h0, 1'b0};
      if (i < sq.size()) g = sq[i];
      checks++;
      if (g.k != e[i].k || g.c != e[i].c || g.d !== e[i].d || g.ch !== e[i].ch) begin
        errors++; $display("FAIL resume_strobe%0d got dut%0d c%0d %h ch%b want dut%0d c%0d %h ch%b", i, g.k, g.c, g.d, g.ch, e[i].k, e[i].c, e[i].d, e[i].ch);
      end
    end
  endtask

  task automatic test_reset_midword();
    st e [4];
    st g;
    e = '{'{0, 199, 24'h654321, 1'b0}, '{2, 199, 24'h654321, 1'b0},
          '{1, 455, 24'h111111, 1'b1}, '{2, 455, 24'h111111, 1'b1}};
    lw = 24'h654321; rw = 24'h111111;
    start();
    step_to(124);
    checks++;
    if (sck[2] !== 1'b1) begin errors++; $display("FAIL pre_reset_sck got %b want 1", sck[2]); end
    #2 rst_n = 1'b0; en = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({sck[k], ws[k], v[k], ch[k], smp[k]} !== 28'd0) begin errors++; $display("FAIL async_clear dut%0d got %h want 0", k, {sck[k], ws[k], v[k], ch[k], smp[k]}); end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (sq.size() != 0) begin errors++; $display("FAIL partial_word_strobe got %0d want 0", sq.size()); end
    rst_n = 1'b1;
    start();
    step_to(80); en = 1'b0;
    step_to(700);
    checks++;
    if (sq.size() != 4) begin errors++; $display("FAIL restart_count got %0d want 4", sq.size()); end
    for (int i = 0; i < 4; i++) begin
      g = '{-1, -1, 24'h0, 1'b0};
      if (i < sq.size()) g = sq[i];
      checks++;
      if (g.k != e[i].k || g.c != e[i].c || g.d !== e[i].d || g.ch !== e[i].ch) begin
        errors++; $display("FAIL restart_strobe%0d got dut%0d c%0d %h ch%b want dut%0d c%0d %h ch%b", i, g.k, g.c, g.d, g.ch, e[i].k, e[i].c, e[i].d, e[i].ch);
      end
    end
  endtask

  initial begin
    test_reset();
    test_left_only();
    test_both_channels();
    test_ignored_slots();
    test_stop_resume();
    test_reset_midword();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/i2s_rx_master.md
# i2s_rx_master

I²S master receiver for a MEMS microphone front end. Generates SCK and WS, deserialises 24-bit two's-complement words from the mic data line, and emits one-cycle `sample_valid_o` strobes with `sample_o`. The pair drives the audio chain directly, e.g. the activity-envelope / LED-level block. It is the producer end of the `sample_valid`/`sample` interface.

## Interface
- `CLK_DIV`, default 4: SCK half-period in `clk_i` cycles. SCK period is 2·CLK_DIV and frame rate is clk/(128·CLK_DIV). Constraint: CLK_DIV ≥ SYNC_STAGES+1.
- `SYNC_STAGES`, default 2: flop stages on `sd_i`, which also sets the capture offset after each SCK rise.
- `CHANNEL_MODE`, default 0: 0 = emit left only, 1 = right only, 2 = both.

Ports:
- `clk_i`  in  1: system clock; single clock domain.
- `rst_ni`  in  1: reset, asynchronous, active-low.
- `enable_i`  in  1: run request; level-sensitive.
- `sd_i`  in  1: serial data from mic; asynchronous, synchronised internally.
- `sck_o`  out  1: I²S bit clock, registered.
- `ws_o`  out  1: word select, registered; 0 = left, 1 = right.
- `sample_valid_o`  out  1: one-cycle strobe, new sample.
- `sample_o`  out  24: signed sample, held until the next strobe.
- `channel_o`  out  1: channel of `sample_o`; 0 = left.

## Operation
- **Counters**
  - Phase counter 0..2·CLK_DIV−1; `sck_o` = 1 when phase ≥ CLK_DIV.
  - Slot counter 0..63 increments on phase wrap, which is the SCK falling edge.
  - `ws_o` = slot[5]: slots 0–31 are left, 32–63 are right. WS changes on the falling edge.
- **Capture**
  - Standard I²S one-bit delay: the MSB is in slot 1 (left) or slot 33 (right). Bits are in slots 1–24 and 33–56, MSB first.
  - Slots 0, 25–32 and 57–63 are ignored.
  - Bit capture: the synchronised `sd_i` is shifted in when phase = CLK_DIV+SYNC_STAGES. This is before the next SCK fall, so mic data driven on the fall is stable.
- **Output strobe**
  - After the capture of slot 24 or slot 56, the register updates in the next cycle: `sample_o` ← shift register, `channel_o` ← ws, `sample_valid_o` = 1 for one cycle.
  - Only channels allowed by CHANNEL_MODE strobe. The other channel is still clocked, but its output registers are untouched.
- **FSM**
  - IDLE: sck=0, ws=0, phase=slot=0. Moves to RUN when `enable_i`=1.
  - RUN: counters run. Moves to STOPPING when `enable_i`=0.
  - STOPPING: counters keep running. Returns to RUN if `enable_i` goes back to 1, with no gap or reset of the counters. Moves to IDLE at the frame end, i.e. the wrap from slot 63/last phase.
  - A frame in progress is always completed, so a right sample pending in that frame is still emitted.
- **Reset**: asynchronous reset forces IDLE and clears the shift register and counters, with no strobe. A partial word is discarded.

## Timing
- **Reset values**: `sck_o`=0, `ws_o`=0, `sample_valid_o`=0, `sample_o`=0, `channel_o`=0.
- **Startup**
  - The cycle after `enable_i` is sampled high in IDLE is RUN slot 0, phase 0. Call it cycle 0.
  - The first SCK rise is at cycle CLK_DIV.
- **Strobe position**
  - Left strobe at cycle 24·2·CLK_DIV + CLK_DIV + SYNC_STAGES + 1, which is 199 for the defaults.
  - Right strobe 32·2·CLK_DIV later, which is 455 for the defaults.
  - The strobe repeats every 128·CLK_DIV cycles per channel.
- **Hold**: `sample_o`/`channel_o` change only in the strobe cycle.
- **Stop**: after deassertion, `sck_o` is low and `ws_o` is 0 from the first cycle after the frame-end wrap.

## Test plan
Defaults unless noted; the mic model drives `sd_i` on SCK falling edges.
1. Reset with `enable_i`=0 for 1000 cycles → all outputs 0, `sck_o` never toggles. Assert `rst_ni` low asynchronously mid-cycle → outputs clear without waiting for a clock edge.
2. Enable; left word 0x800001 → single strobe at cycle 199, `sample_o`=0x800001 (−8388607), `channel_o`=0. No right strobe (CHANNEL_MODE=0). SCK period is 8 cycles and WS toggles every 256 cycles.
3. CHANNEL_MODE=2; left 0x123456, right 0x7FFFFF → strobes at 199 and 455 with channels 0 and 1. Repeats at 711 and 967 for the next frame.
4. Drive 1s in slots 0 and 25–32 with a left word of 0x000000 → `sample_o`=0x000000; the ignored slots have no effect.
5. CHANNEL_MODE=2; deassert `enable_i` in slot 10 → the left and right strobes of that frame still occur, then IDLE with `sck_o`=0. A re-assert in slot 40 instead → RUN continues with no gap in SCK.
6. Pulse `rst_ni` low during slot 15 of a left word → no strobe for that word. After re-enable, the first strobe is exactly 199 cycles after RUN entry with the correct value.
